alu_exec: RTL and testbench

Execute stage of the 16-bit datapath: consumes the two operands read from the register bank plus a decoded opcode and destination index. It produces a registered write-back (write enable, address, data) that drives the register bank write port directly, and updates the condition flags. Single-cycle ALU operations finish in one cycle; multiply uses an iterative shift-add unit and holds the stage busy until it finishes.

---
 rtl/alu_exec.sv | 241 ++++++++++++++++++++++++
 tb/tb_alu_exec.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - execute stage: 16-bit ALU with registered write-back and flags
//
// Purpose:
//   Takes two register-bank operands, an opcode and a destination index.
//   Single-cycle ops retire one cycle after accept; MUL runs on an iterative
//   shift-add unit and keeps the stage busy until it retires.
//
// Build option:
//   ALU_MUL_EN  defined   -> iterative multiplier present (opcode 9 = MUL)
//               undefined -> opcode 9 is reserved, busy tied to 0
//
// Ports:
//   clk     in   1   system clock, rising edge
//   rst     in   1   asynchronous active-high reset
//   start   in   1   issue request, accepted only when busy=0
//   op      in   4   opcode, sampled on accept
//   dest    in   4   destination register index, sampled on accept
//   opA     in  16   operand A, sampled on accept
//   opB     in  16   operand B, sampled on accept
//   busy    out  1   multi-cycle operation in progress
//   done    out  1   one-cycle retire pulse
//   write   out  1   register bank write enable, coincident with done
//   wrAddr  out  4   write-back register index (holds when write=0)
//   wrData  out 16   write-back data (holds when write=0)
//   flagZ   out  1   zero flag
//   flagC   out  1   carry / borrow flag
//   flagN   out  1   negative flag

module alu_exec (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [3:0]  dest,
  input  logic [15:0] opA,
  input  logic [15:0] opB,
  output logic        busy,
  output logic        done,
  output logic        write,
  output logic [3:0]  wrAddr,
  output logic [15:0] wrData,
  output logic        flagZ,
  output logic        flagC,
  output logic        flagN
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MOV = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;

  // ---------------------------------------------------------------------
  // Single-cycle ALU (combinational on the live operands)
  // ---------------------------------------------------------------------
  logic [16:0] w_sum;
  logic [15:0] w_diff;
  logic [31:0] w_shl;
  logic [31:0] w_shr;
  logic [15:0] w_res;
  logic        w_c;
  logic        w_wr;
  logic        w_upd;

  assign w_sum  = {1'b0, opA} + {1'b0, opB};
  assign w_diff = opA - opB;
  // Shifting through a 32-bit window leaves the last bit shifted out at a
  // fixed position (bit 16 for SHL, bit 15 for SHR); it is 0 for a zero shift.
  assign w_shl  = {16'h0000, opA} << opB[3:0];
  assign w_shr  = {opA, 16'h0000} >> opB[3:0];

  always_comb begin
    w_res = 16'h0000;
    w_c   = 1'b0;
    w_wr  = 1'b0;
    w_upd = 1'b0;
    case (op)
      OP_ADD: begin w_res = w_sum[15:0];   w_c = w_sum[16];   w_wr = 1'b1; w_upd = 1'b1; end
      OP_SUB: begin w_res = w_diff;        w_c = (opA < opB); w_wr = 1'b1; w_upd = 1'b1; end
      OP_AND: begin w_res = opA & opB;                        w_wr = 1'b1; w_upd = 1'b1; end
      OP_OR:  begin w_res = opA | opB;                        w_wr = 1'b1; w_upd = 1'b1; end
      OP_XOR: begin w_res = opA ^ opB;                        w_wr = 1'b1; w_upd = 1'b1; end
      OP_NOT: begin w_res = ~opA;                             w_wr = 1'b1; w_upd = 1'b1; end
      OP_SHL: begin w_res = w_shl[15:0];   w_c = w_shl[16];   w_wr = 1'b1; w_upd = 1'b1; end
      OP_SHR: begin w_res = w_shr[31:16];  w_c = w_shr[15];   w_wr = 1'b1; w_upd = 1'b1; end
      OP_MOV: begin w_res = opB;                              w_wr = 1'b1; w_upd = 1'b1; end
      OP_CMP: begin w_res = w_diff;        w_c = (opA < opB);              w_upd = 1'b1; end
      // MUL is handled by the iterative unit; 11-15 are reserved and retire
      // without a write or flag update.
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Accept control and multiplier
  // ---------------------------------------------------------------------
  logic        w_alu_accept;  // single-cycle op retires next cycle
  logic        w_mul_ret;     // multiplier finishes on this edge
  logic [3:0]  w_mul_dest;
  logic [15:0] w_mul_data;
  logic        w_mul_c;

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_RET  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_mcand;
  logic [15:0] r_mplier;
  logic [31:0] r_acc;
  logic [3:0]  r_cnt;
  logic [3:0]  r_dest;
  logic [31:0] w_acc_next;
  logic        w_idle_start;

  assign w_idle_start = start && (r_state == ST_IDLE);
  assign w_alu_accept = w_idle_start && (op != OP_MUL);
  assign w_acc_next   = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  // The result is registered on the edge that enters RET, so done/write and
  // the final product are visible for exactly the RET cycle.
  assign w_mul_ret    = (r_state == ST_MUL) && (r_cnt == 4'd15);
  assign w_mul_dest   = r_dest;
  assign w_mul_data   = w_acc_next[15:0];
  assign w_mul_c      = |w_acc_next[31:16];
  assign busy         = (r_state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_idle_start && (op == OP_MUL)) w_state_next = ST_MUL;
      ST_MUL:  if (r_cnt == 4'd15)                 w_state_next = ST_RET;
      ST_RET:                                      w_state_next = ST_IDLE;
      default:                                     w_state_next = ST_IDLE;
    endcase
  end

  // Operands are captured at accept so later bank writes cannot disturb
  // the product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand  <= 32'h0;
      r_mplier <= 16'h0;
      r_acc    <= 32'h0;
      r_cnt    <= 4'd0;
      r_dest   <= 4'd0;
    end else if (w_idle_start && (op == OP_MUL)) begin
      r_mcand  <= {16'h0000, opA};
      r_mplier <= opB;
      r_acc    <= 32'h0;
      r_cnt    <= 4'd0;
      r_dest   <= dest;
    end else if (r_state == ST_MUL) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 4'd1;
    end
  end
`else
  assign w_alu_accept = start;
  assign w_mul_ret    = 1'b0;
  assign w_mul_dest   = 4'd0;
  assign w_mul_data   = 16'h0000;
  assign w_mul_c      = 1'b0;
  assign busy         = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Write-back and flag registers
  // ---------------------------------------------------------------------
  logic        r_done;
  logic        r_write;
  logic [3:0]  r_wr_addr;
  logic [15:0] r_wr_data;
  logic        r_z;
  logic        r_c;
  logic        r_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done    <= 1'b0;
      r_write   <= 1'b0;
      r_wr_addr <= 4'd0;
      r_wr_data <= 16'h0000;
      r_z       <= 1'b0;
      r_c       <= 1'b0;
      r_n       <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_write <= 1'b0;
      if (w_alu_accept) begin
        r_done  <= 1'b1;
        r_write <= w_wr;
        if (w_wr) begin
          r_wr_addr <= dest;
          r_wr_data <= w_res;
        end
        if (w_upd) begin
          r_z <= (w_res == 16'h0000);
          r_c <= w_c;
          r_n <= w_res[15];
        end
      end else if (w_mul_ret) begin
        r_done    <= 1'b1;
        r_write   <= 1'b1;
        r_wr_addr <= w_mul_dest;
        r_wr_data <= w_mul_data;
        r_z       <= (w_mul_data == 16'h0000);
        r_c       <= w_mul_c;
        r_n       <= w_mul_data[15];
      end
    end
  end

  assign done   = r_done;
  assign write  = r_write;
  assign wrAddr = r_wr_addr;
  assign wrData = r_wr_data;
  assign flagZ  = r_z;
  assign flagC  = r_c;
  assign flagN  = r_n;

endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - directed scoreboard bench for alu_exec

module tb_alu_exec;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  op;
  logic [3:0]  dest;
  logic [15:0] opA;
  logic [15:0] opB;
  logic        busy;
  logic        done;
  logic        write;
  logic [3:0]  wrAddr;
  logic [15:0] wrData;
  logic        flagZ;
  logic        flagC;
  logic        flagN;

  alu_exec dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .dest   (dest),
    .opA    (opA),
    .opB    (opB),
    .busy   (busy),
    .done   (done),
    .write  (write),
    .wrAddr (wrAddr),
    .wrData (wrData),
    .flagZ  (flagZ),
    .flagC  (flagC),
    .flagN  (flagN)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [3:0]  addr;
    logic [15:0] data;
    logic        z;
    logic        c;
    logic        n;
  } exp_t;

  exp_t q[$];
  exp_t m_last;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected retire with a register write.
  task automatic push_wr(input logic [3:0] a, input logic [15:0] d,
                         input logic z, input logic c, input logic n);
    exp_t e;
    e = '{wr: 1'b1, addr: a, data: d, z: z, c: c, n: n};
    q.push_back(e);
    m_last = e;
  endtask

  // Expected retire without a write but with new flags (CMP).
  task automatic push_flags(input logic z, input logic c, input logic n);
    exp_t e;
    e = m_last;
    e.wr = 1'b0; e.z = z; e.c = c; e.n = n;
    q.push_back(e);
    m_last = e;
  endtask

  // Expected retire of a reserved opcode: nothing changes.
  task automatic push_reserved();
    exp_t e;
    e = m_last;
    e.wr = 1'b0;
    q.push_back(e);
  endtask

  // Advance to the next falling edge and score any retire seen there.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_done", {31'b0, done}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("write",  {31'b0, write},  {31'b0, e.wr});
        chk("wrAddr", {28'b0, wrAddr}, {28'b0, e.addr});
        chk("wrData", {16'b0, wrData}, {16'b0, e.data});
        chk("flagZ",  {31'b0, flagZ},  {31'b0, e.z});
        chk("flagC",  {31'b0, flagC},  {31'b0, e.c});
        chk("flagN",  {31'b0, flagN},  {31'b0, e.n});
      end
    end
  endtask

  task automatic issue(input logic [3:0] o, input logic [3:0] d,
                       input logic [15:0] a, input logic [15:0] b, input bit single);
    start = 1'b1; op = o; dest = d; opA = a; opB = b;
    tick();
    start = 1'b0;
    if (single) chk("done_latency", {31'b0, done}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"},   {31'b0, busy},   32'd0);
    chk({tag, "_done"},   {31'b0, done},   32'd0);
    chk({tag, "_write"},  {31'b0, write},  32'd0);
    chk({tag, "_wrAddr"}, {28'b0, wrAddr}, 32'd0);
    chk({tag, "_wrData"}, {16'b0, wrData}, 32'd0);
    chk({tag, "_flags"},  {29'b0, flagZ, flagC, flagN}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; op = 4'd0; dest = 4'd0; opA = 16'h0; opB = 16'h0;
    m_last = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // No retire without a request.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_done", {31'b0, done}, 32'd0);
    end

    // ADD wrap-around into register 3.
    push_wr(4'd3, 16'h0000, 1'b1, 1'b1, 1'b0);
    issue(4'd0, 4'd3, 16'hFFFF, 16'h0001, 1);

    // SUB then CMP back to back.
    push_wr(4'd1, 16'hFFFE, 1'b0, 1'b1, 1'b1);
    issue(4'd1, 4'd1, 16'h0005, 16'h0007, 1);
    push_flags(1'b1, 1'b0, 1'b0);
    issue(4'd10, 4'd2, 16'h0005, 16'h0005, 1);

    // Shifts, including zero and maximum shift counts.
    push_wr(4'd15, 16'h0002, 1'b0, 1'b1, 1'b0);
    issue(4'd6, 4'd15, 16'h8001, 16'h0001, 1);
    push_wr(4'd4, 16'h0003, 1'b0, 1'b0, 1'b0);
    issue(4'd7, 4'd4, 16'h0003, 16'h0000, 1);
    push_wr(4'd5, 16'h0001, 1'b0, 1'b0, 1'b0);
    issue(4'd7, 4'd5, 16'h8000, 16'h000F, 1);
    push_wr(4'd6, 16'h8000, 1'b0, 1'b0, 1'b1);
    issue(4'd6, 4'd6, 16'h0001, 16'h000F, 1);
    push_wr(4'd7, 16'h0FFF, 1'b0, 1'b1, 1'b0);
    issue(4'd7, 4'd7, 16'hFFFF, 16'h0004, 1);

    // Logic ops, MOV, positive SUB, signed overflow ADD, register 0.
    push_wr(4'd0, 16'h00F0, 1'b0, 1'b0, 1'b0);
    issue(4'd2, 4'd0, 16'hF0F0, 16'h0FF0, 1);
    push_wr(4'd8, 16'h8001, 1'b0, 1'b0, 1'b1);
    issue(4'd3, 4'd8, 16'h8000, 16'h0001, 1);
    push_wr(4'd9, 16'h0000, 1'b1, 1'b0, 1'b0);
    issue(4'd4, 4'd9, 16'hAAAA, 16'hAAAA, 1);
    push_wr(4'd10, 16'hFF00, 1'b0, 1'b0, 1'b1);
    issue(4'd5, 4'd10, 16'h00FF, 16'h1234, 1);
    push_wr(4'd11, 16'h1234, 1'b0, 1'b0, 1'b0);
    issue(4'd8, 4'd11, 16'hFFFF, 16'h1234, 1);
    push_wr(4'd12, 16'h0002, 1'b0, 1'b0, 1'b0);
    issue(4'd1, 4'd12, 16'h0007, 16'h0005, 1);
    push_wr(4'd13, 16'h8000, 1'b0, 1'b0, 1'b1);
    issue(4'd0, 4'd13, 16'h7FFF, 16'h0001, 1);

    // Reserved opcode: retires with write=0, everything else held.
    push_reserved();
    issue(4'd12, 4'd14, 16'h1111, 16'h2222, 1);
    tick();
    chk("after_reserved_done", {31'b0, done}, 32'd0);

`ifdef ALU_MUL_EN
    // MUL: busy for 17 cycles, retire in the 17th, ignored mid-op start.
    push_wr(4'd7, 16'h1230, 1'b0, 1'b0, 1'b0);
    issue(4'd9, 4'd7, 16'h0123, 16'h0010, 0);
    chk("mul_busy_1", {31'b0, busy}, 32'd1);
    for (int k = 2; k <= 17; k++) begin
      if (k == 5) begin
        start = 1'b1; op = 4'd0; dest = 4'd2; opA = 16'h0001; opB = 16'h0001;
      end
      tick();
      start = 1'b0;
      chk("mul_busy", {31'b0, busy}, 32'd1);
      chk("mul_done_cycle", {31'b0, done}, (k == 17) ? 32'd1 : 32'd0);
    end
    tick();
    chk("mul_busy_release", {31'b0, busy}, 32'd0);

    // MUL with overflow into the discarded high half.
    push_wr(4'd8, 16'h0000, 1'b1, 1'b1, 1'b0);
    issue(4'd9, 4'd8, 16'h8000, 16'h0002, 0);
    begin
      int n;
      n = 0;
      while (done !== 1'b1 && n < 25) begin
        tick();
        n++;
      end
      chk("mul2_retire", {31'b0, done}, 32'd1);
    end
    tick();
    chk("mul2_busy_release", {31'b0, busy}, 32'd0);

    // Reset in the middle of a MUL aborts it with no write.
    issue(4'd9, 4'd9, 16'h00FF, 16'h00FF, 0);
    repeat (7) tick();
    chk("abort_busy_before", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    @(negedge clk);
    rst = 1'b0;
    m_last = '0;
`else
    // Without the multiplier opcode 9 is reserved and never busy.
    push_reserved();
    issue(4'd9, 4'd7, 16'h0123, 16'h0010, 1);
    chk("nomul_busy", {31'b0, busy}, 32'd0);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst2");
    @(negedge clk);
    rst = 1'b0;
    m_last = '0;
`endif

    // Normal single-cycle retire after reset.
    push_wr(4'd9, 16'h0003, 1'b0, 1'b0, 1'b0);
    issue(4'd0, 4'd9, 16'h0001, 16'h0002, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("tail_done", {31'b0, done}, 32'd0);
    end

    chk("queue_empty", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
